// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: pipeline wb priority over an in-order long-latency result FIFO, busy scoreboard, starve stall
// Optional macro WB_ARBITER_BYPASS_EN: an lu result arriving at an empty FIFO with no wb goes straight to rf.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [4:0]               lu_reg,
    input  logic [31:0]              lu_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_reg,
    output logic [31:0]              busy,
    output logic [4:0]               rf_reg,
    output logic [31:0]              rf_data,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_mem_reg  [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_busy;
    logic [4:0]    r_rf_reg;
    logic [31:0]   r_rf_data;
    logic          r_stall;

    logic          w_wb, w_empty, w_accept, w_push, w_pop;
    logic [4:0]    w_head_reg;
    logic [31:0]   w_head_data;
    logic [CW-1:0] w_count_next;
    logic [SW-1:0] w_starve_next;
    logic [31:0]   w_busy_next;

    // A wb to r0 is not a real write, so it leaves the rf slot free for a pop.
    assign w_wb        = wb_valid && (wb_reg != 5'd0);
    assign w_empty     = (r_count == '0);
    assign lu_ready    = (r_count != CW'(DEPTH));
    assign w_accept    = lu_valid && lu_ready;
    assign w_pop       = !w_wb && !w_empty;
    assign w_head_reg  = r_mem_reg[r_rptr];
    assign w_head_data = r_mem_data[r_rptr];

`ifdef WB_ARBITER_BYPASS_EN
    logic w_byp;
    assign w_byp  = w_empty && w_accept && !w_wb;
    assign w_push = w_accept && !w_byp;
`else
    assign w_push = w_accept;
`endif

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_count_next = r_count - CW'(1);
    end

    always_comb begin
        w_starve_next = r_starve;
        if (w_empty || w_pop)
            w_starve_next = '0;
        else if (r_starve != SW'(STARVE_LIMIT))
            w_starve_next = r_starve + SW'(1);
    end

    // Clears first, then the issue set, so a same-edge set of the same register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop)
            w_busy_next[w_head_reg] = 1'b0;
`ifdef WB_ARBITER_BYPASS_EN
        if (w_byp)
            w_busy_next[lu_reg] = 1'b0;
`endif
        if (issue_valid)
            w_busy_next[issue_reg] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_reg[r_wptr]  <= lu_reg;
            r_mem_data[r_wptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_busy    <= '0;
            r_rf_reg  <= '0;
            r_rf_data <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count  <= w_count_next;
            r_starve <= w_starve_next;
            r_stall  <= (w_starve_next == SW'(STARVE_LIMIT));
            r_busy   <= w_busy_next;
            if (w_wb) begin
                r_rf_reg  <= wb_reg;
                r_rf_data <= wb_data;
            end else if (w_pop) begin
                r_rf_reg  <= w_head_reg;
                r_rf_data <= w_head_data;
`ifdef WB_ARBITER_BYPASS_EN
            end else if (w_byp) begin
                r_rf_reg  <= lu_reg;
                r_rf_data <= lu_data;
`endif
            end else begin
                r_rf_reg  <= '0;
                r_rf_data <= '0;
            end
        end
    end

    assign busy       = r_busy;
    assign rf_reg     = r_rf_reg;
    assign rf_data    = r_rf_data;
    assign stall_req  = r_stall;
    assign fifo_count = r_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [31:0] busy;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;
    logic        stall_req;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .busy(busy), .rf_reg(rf_reg), .rf_data(rf_data),
        .stall_req(stall_req), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_reg = 0; wb_data = 0;
        lu_valid = 0; lu_reg = 0; lu_data = 0;
        issue_valid = 0; issue_reg = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        #2;
        n_vec++; if (rf_reg !== 5'd0) begin n_err++; $display("FAIL reset_rf_reg got %0d exp 0", rf_reg); end
        n_vec++; if (rf_data !== 32'd0) begin n_err++; $display("FAIL reset_rf_data got %h exp 0", rf_data); end
        n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL reset_busy got %h exp 0", busy); end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        n_vec++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall_req); end
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL reset_lu_ready got %b exp 1", lu_ready); end
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_wb_write();
        wb_valid = 1; wb_reg = 5; wb_data = 32'hDEADBEEF;
        tick();
        n_vec++; if (rf_reg !== 5'd5) begin n_err++; $display("FAIL wb_rf_reg got %0d exp 5", rf_reg); end
        n_vec++; if (rf_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wb_rf_data got %h exp deadbeef", rf_data); end
        idle_inputs();
        tick();
        n_vec++; if (rf_reg !== 5'd0) begin n_err++; $display("FAIL wb_idle_rf_reg got %0d exp 0", rf_reg); end
    endtask

    task automatic test_issue_pop();
        issue_valid = 1; issue_reg = 9;
        tick();
        n_vec++; if (busy !== 32'h0000_0200) begin n_err++; $display("FAIL issue9_busy got %h exp 00000200", busy); end
        idle_inputs();
        lu_valid = 1; lu_reg = 9; lu_data = 32'h1234;
        tick();
        idle_inputs();
`ifndef WB_ARBITER_BYPASS_EN
        n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL lu9_count got %0d exp 1", fifo_count); end
        n_vec++; if (rf_reg !== 5'd0) begin n_err++; $display("FAIL lu9_early_rf_reg got %0d exp 0", rf_reg); end
        n_vec++; if (busy[9] !== 1'b1) begin n_err++; $display("FAIL lu9_busy_hold got %b exp 1", busy[9]); end
        tick();
`endif
        n_vec++; if (rf_reg !== 5'd9) begin n_err++; $display("FAIL lu9_rf_reg got %0d exp 9", rf_reg); end
        n_vec++; if (rf_data !== 32'h1234) begin n_err++; $display("FAIL lu9_rf_data got %h exp 1234", rf_data); end
        n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL lu9_busy_clear got %h exp 0", busy); end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL lu9_count_after got %0d exp 0", fifo_count); end
        tick();
    endtask

    task automatic test_fill_starve();
        wb_valid = 1; wb_reg = 1; wb_data = 32'hAAAA0001;
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1; lu_reg = 5'(10 + i); lu_data = 32'h100 + i;
            tick();
        end
        // A fifth offer while full must be refused.
        lu_reg = 20; lu_data = 32'h999;
        n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", fifo_count); end
        n_vec++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL full_lu_ready got %b exp 0", lu_ready); end
        n_vec++; if (rf_reg !== 5'd1) begin n_err++; $display("FAIL full_rf_wb got %0d exp 1", rf_reg); end
        // Starve counter went 0 at edge 1, 1..3 at edges 2..4; edges 5..8 bring it to 7.
        for (int i = 0; i < 4; i++) tick();
        n_vec++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL starve7_stall got %b exp 0", stall_req); end
        tick();
        n_vec++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL starve8_stall got %b exp 1", stall_req); end
        n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL refuse_count got %0d exp 4", fifo_count); end
        wb_reg = 2; wb_data = 32'hBBBB0002;
        lu_valid = 0;
        tick();
        n_vec++; if (rf_reg !== 5'd2 || rf_data !== 32'hBBBB0002) begin n_err++; $display("FAIL stall_wb_prio got %0d/%h exp 2/bbbb0002", rf_reg, rf_data); end
        n_vec++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL stall_saturated got %b exp 1", stall_req); end
        idle_inputs();
        tick();
        n_vec++; if (rf_reg !== 5'd10 || rf_data !== 32'h100) begin n_err++; $display("FAIL pop0 got %0d/%h exp 10/100", rf_reg, rf_data); end
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL pop0_lu_ready got %b exp 1", lu_ready); end
        n_vec++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL pop0_stall got %b exp 0", stall_req); end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_vec++; if (rf_reg !== 5'(10 + i) || rf_data !== 32'h100 + i) begin n_err++; $display("FAIL pop%0d got %0d/%h exp %0d/%h", i, rf_reg, rf_data, 10 + i, 32'h100 + i); end
        end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL drained_count got %0d exp 0", fifo_count); end
        tick();
    endtask

    task automatic test_issue_same_edge();
        issue_valid = 1; issue_reg = 3;
        wb_valid = 1; wb_reg = 2; wb_data = 32'h22;
        lu_valid = 1; lu_reg = 3; lu_data = 32'h33;
        tick();
        idle_inputs();
        issue_valid = 1; issue_reg = 3;
        tick();
        idle_inputs();
        n_vec++; if (rf_reg !== 5'd3 || rf_data !== 32'h33) begin n_err++; $display("FAIL same_edge_pop got %0d/%h exp 3/33", rf_reg, rf_data); end
        n_vec++; if (busy !== 32'h0000_0008) begin n_err++; $display("FAIL same_edge_busy got %h exp 00000008", busy); end
    endtask

    task automatic test_wb_reg0();
        wb_valid = 1; wb_reg = 6; wb_data = 32'h66;
        lu_valid = 1; lu_reg = 4; lu_data = 32'h44;
        tick();
        lu_reg = 0; lu_data = 32'h55;
        tick();
        n_vec++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL r0_count got %0d exp 2", fifo_count); end
        idle_inputs();
        wb_valid = 1; wb_reg = 0; wb_data = 32'hFFFF;
        issue_valid = 1; issue_reg = 0;
        tick();
        n_vec++; if (rf_reg !== 5'd4 || rf_data !== 32'h44) begin n_err++; $display("FAIL wbreg0_pop got %0d/%h exp 4/44", rf_reg, rf_data); end
        n_vec++; if (busy !== 32'h0000_0008) begin n_err++; $display("FAIL issue0_busy got %h exp 00000008", busy); end
        tick();
        idle_inputs();
        n_vec++; if (rf_reg !== 5'd0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL lureg0_pop got %0d/cnt %0d exp 0/0", rf_reg, fifo_count); end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_reg = 7;
        wb_valid = 1; wb_reg = 8; wb_data = 32'h88;
        lu_valid = 1; lu_reg = 7; lu_data = 32'h77;
        tick();
        issue_valid = 0;
        tick();
        tick();
        n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL pre_reset_count got %0d exp 3", fifo_count); end
        n_vec++; if (busy !== 32'h0000_0088) begin n_err++; $display("FAIL pre_reset_busy got %h exp 00000088", busy); end
        #2 reset = 1;
        #1;
        n_vec++; if (rf_reg !== 5'd0 || rf_data !== 32'd0) begin n_err++; $display("FAIL async_rst_rf got %0d/%h exp 0/0", rf_reg, rf_data); end
        n_vec++; if (busy !== 32'd0 || fifo_count !== 3'd0 || stall_req !== 1'b0) begin n_err++; $display("FAIL async_rst_state got busy %h cnt %0d stall %b exp 0", busy, fifo_count, stall_req); end
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready got %b exp 1", lu_ready); end
        idle_inputs();
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (rf_reg !== 5'd0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL post_reset_%0d got rf %0d cnt %0d exp 0/0", i, rf_reg, fifo_count); end
        end
    endtask

    initial begin
        test_reset();
        test_wb_write();
        test_issue_pop();
        test_fill_starve();
        test_issue_same_edge();
        test_wb_reg0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, long-latency result FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, consecutive non-popped cycles before stall_req asserts.
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports wb_valid in 1, wb_reg in 5, wb_data in 32: pipeline writeback, always accepted.
REQ-006 SHALL have ports lu_valid in 1, lu_ready out 1, lu_reg in 5, lu_data in 32: long-latency unit result handshake.
REQ-007 SHALL have ports issue_valid in 1, issue_reg in 5: long-latency op issued to issue_reg.
REQ-008 SHALL have port busy  out  32  scoreboard bit per register, 1 = result pending.
REQ-009 SHALL have ports rf_reg out 5, rf_data out 32: register-file write port; rf_reg = 0 means no write.
REQ-010 SHALL have port stall_req  out  1  request that the pipeline withhold wb_valid next cycle.
REQ-011 SHALL have port fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-012 SHALL store accepted long-latency results in an in-order FIFO of DEPTH entries.
REQ-013 SHALL drive lu_ready = (fifo_count != DEPTH), from registered count only; a full FIFO is not ready even while popping.
REQ-014 SHALL accept lu entry on an edge where lu_valid && lu_ready; lu_reg = 0 entries are accepted, occupy a slot, and produce rf_reg = 0 when popped.
REQ-015 SHALL register rf_reg/rf_data each edge: wb_valid && wb_reg != 0 -> wb_reg/wb_data; else FIFO non-empty -> pop head; else 0/0.
REQ-016 SHALL give wb strict priority; wb_valid with wb_reg = 0 counts as no wb and frees the slot for a pop.
REQ-017 SHALL update count by +1 push, -1 pop, unchanged on simultaneous push and pop.
REQ-018 SHALL set busy[issue_reg] on an edge with issue_valid && issue_reg != 0.
REQ-019 SHALL clear busy[r] on the edge a FIFO entry with lu_reg = r is popped; same-edge set and clear of r -> set wins.
REQ-020 SHALL hold busy[0] = 0 always.
REQ-021 SHALL keep a starve counter: increment (saturate at STARVE_LIMIT) on each edge FIFO non-empty and no pop; reset to 0 on pop or empty FIFO.
REQ-022 SHALL assert stall_req = (starve counter == STARVE_LIMIT), registered.
REQ-023 SHALL still give wb priority if wb_valid arrives while stall_req is high; counter stays saturated.
REQ-024 SHALL write same-register wb and popped entries to rf in arbitration order, later edge wins.

Reset
REQ-025 SHALL on reset force rf_reg = 0, rf_data = 0, busy = 0, fifo_count = 0, stall_req = 0, starve counter = 0, immediately and asynchronously.
REQ-026 SHALL drive lu_ready = 1 during and after reset; a reset mid-operation discards all FIFO contents and pending busy bits.

Configuration
REQ-027 SHALL compile a bypass path only when macro WB_ARBITER_BYPASS_EN is defined.
REQ-028 SHALL, with WB_ARBITER_BYPASS_EN, on an edge with FIFO empty, lu accepted, and no wb, load the entry directly into rf_reg/rf_data and clear busy for it, without a push (count unchanged).
REQ-029 SHALL, without WB_ARBITER_BYPASS_EN, always push accepted entries; rf_reg shows an entry accepted at edge k no earlier than edge k+1.

Verification
REQ-030 SHALL cover: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF, FIFO empty -> next edge rf_reg=5, rf_data=0xDEADBEEF.
REQ-031 SHALL cover: issue reg 9; lu push reg 9 data 0x1234, no wb -> busy[9]=1 then rf_reg=9 with 0x1234 at edge k+1 (k with bypass), busy[9]=0 same edge.
REQ-032 SHALL cover: 4 lu pushes with wb_valid continuous -> fifo_count=4, lu_ready=0, stall_req=1 after 8 non-pop edges; drop wb -> in-order pops, lu_ready=1 after first.
REQ-033 SHALL cover: issue reg 3 on the same edge an entry for reg 3 pops -> busy[3]=1 after the edge.
REQ-034 SHALL cover: reset asserted with count=3, busy[7]=1 -> all outputs 0, lu_ready=1, no writes after reset release.
REQ-035 SHALL cover: wb_reg=0 with FIFO non-empty -> head popped that edge; issue_reg=0 -> busy stays 0.
